// File: rtl/radix4_seq_mul_if.sv
// ---------------------------------------------------------------------------
// radix4_seq_mul_if
// Handshake and data bundle for the radix-4 sequential multiplier.
//   start        requester -> multiplier : begin a multiply (taken when busy=0)
//   signed_mode  requester -> multiplier : 1 = two's complement, 0 = unsigned
//   mcand        requester -> multiplier : multiplicand, WIDTH bits
//   mplr         requester -> multiplier : multiplier, WIDTH bits
//   busy         multiplier -> requester : operation in progress
//   done         multiplier -> requester : one-cycle pulse, prod valid
//   prod         multiplier -> requester : product, 2*WIDTH bits, held
// ---------------------------------------------------------------------------
interface radix4_seq_mul_if #(
   parameter int WIDTH = 8
);
   logic                   start;
   logic                   signed_mode;
   logic [WIDTH-1:0]       mcand;
   logic [WIDTH-1:0]       mplr;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     prod;

   modport master (
      output start, signed_mode, mcand, mplr,
      input  busy, done, prod
   );

   modport slave (
      input  start, signed_mode, mcand, mplr,
      output busy, done, prod
   );
endinterface

// File: rtl/radix4_seq_mul.sv
// ---------------------------------------------------------------------------
// radix4_seq_mul
// Sequential sign/magnitude multiplier retiring two multiplier bits per cycle.
// A request is taken when busy=0; the product appears WIDTH/2+1 cycles later
// with a one-cycle done pulse and is held until the next result.
//   clk   rising-edge clock
//   rst   synchronous active-high reset, overrides everything
//   bus   radix4_seq_mul_if.slave: start/signed_mode/mcand/mplr in,
//         busy/done/prod out (all outputs registered)
// WIDTH must be even and >= 4.
// ---------------------------------------------------------------------------
module radix4_seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   radix4_seq_mul_if.slave   bus
);

   localparam int CW = $clog2(WIDTH/2) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH/2 - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_r;
   logic [WIDTH-1:0]     mag_a_r;
   logic [WIDTH-1:0]     mag_b_r;
   logic                 sign_r;
   logic [CW-1:0]        cnt_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [2*WIDTH-1:0]   prod_r;
   logic                 busy_r;
   logic                 done_r;

   logic                 a_neg_s;
   logic                 b_neg_s;
   logic [WIDTH-1:0]     a_mag_s;
   logic [WIDTH-1:0]     b_mag_s;
   logic                 sign_s;
   logic [WIDTH+1:0]     pp_s;
   logic [2*WIDTH-1:0]   acc_next_s;
   logic [2*WIDTH-1:0]   res_s;

   // Operand magnitudes and result sign for capture. The most negative value
   // negates to itself, which read as unsigned is exactly its magnitude.
   // A zero operand forces a positive result so no negative zero is produced.
   always_comb begin
      a_neg_s = bus.signed_mode & bus.mcand[WIDTH-1];
      b_neg_s = bus.signed_mode & bus.mplr[WIDTH-1];
      if (a_neg_s) begin
         a_mag_s = (~bus.mcand) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         a_mag_s = bus.mcand;
      end
      if (b_neg_s) begin
         b_mag_s = (~bus.mplr) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         b_mag_s = bus.mplr;
      end
      sign_s = (a_neg_s ^ b_neg_s) & (|bus.mcand) & (|bus.mplr);
   end

   // Radix-4 partial product (0/1x/2x/3x) at WIDTH+2 bits, the accumulator
   // update for this iteration and the signed final result.
   always_comb begin
      case (mag_b_r[1:0])
         2'b00:   pp_s = {(WIDTH+2){1'b0}};
         2'b01:   pp_s = {2'b00, mag_a_r};
         2'b10:   pp_s = {1'b0, mag_a_r, 1'b0};
         2'b11:   pp_s = {2'b00, mag_a_r} + {1'b0, mag_a_r, 1'b0};
         default: pp_s = {(WIDTH+2){1'b0}};
      endcase
      acc_next_s = acc_r + ({{(WIDTH-2){1'b0}}, pp_s} << {cnt_r, 1'b0});
      if (sign_r) begin
         res_s = (~acc_next_s) + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
         res_s = acc_next_s;
      end
   end

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         mag_a_r <= {WIDTH{1'b0}};
         mag_b_r <= {WIDTH{1'b0}};
         sign_r  <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         acc_r   <= {(2*WIDTH){1'b0}};
         prod_r  <= {(2*WIDTH){1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               // Start is honoured in DONE too, giving back-to-back issue.
               if (bus.start) begin
                  mag_a_r <= a_mag_s;
                  mag_b_r <= b_mag_s;
                  sign_r  <= sign_s;
                  cnt_r   <= {CW{1'b0}};
                  acc_r   <= {(2*WIDTH){1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               acc_r   <= acc_next_s;
               mag_b_r <= mag_b_r >> 2'd2;
               cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_r == LAST_ITER) begin
                  prod_r  <= res_s;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= DONE;
               end else begin
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.prod = prod_r;

endmodule

// File: tb/tb_radix4_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_radix4_seq_mul
// Directed checks of an 8-bit instance (reset, unsigned, signed, ignored
// start, reset abort, back-to-back) and a 16-bit instance with extreme and
// random operand pairs against a reference product.
// ---------------------------------------------------------------------------
module tb_radix4_seq_mul;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   radix4_seq_mul_if #(.WIDTH(8))  b8  ();
   radix4_seq_mul_if #(.WIDTH(16)) b16 ();

   radix4_seq_mul #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
   radix4_seq_mul #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One 8-bit multiply: 4 busy cycles, done in cycle 5, prod held after.
   task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input string name);
      b8.signed_mode = sm;
      b8.mcand       = a;
      b8.mplr        = b;
      b8.start       = 1'b1;
      @(negedge clk);
      b8.start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         total++;
         if (b8.busy !== 1'b1 || b8.done !== 1'b0) begin
            bad++;
            $display("FAIL %s run cycle %0d: busy=%b done=%b, want busy=1 done=0",
                     name, i, b8.busy, b8.done);
         end
         @(negedge clk);
      end
      total++;
      if (b8.done !== 1'b1 || b8.busy !== 1'b0 || b8.prod !== exp) begin
         bad++;
         $display("FAIL %s done cycle: done=%b busy=%b prod=%h, want done=1 busy=0 prod=%h",
                  name, b8.done, b8.busy, b8.prod, exp);
      end
      @(negedge clk);
      total++;
      if (b8.done !== 1'b0 || b8.prod !== exp) begin
         bad++;
         $display("FAIL %s hold: done=%b prod=%h, want done=0 prod=%h",
                  name, b8.done, b8.prod, exp);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      b8.start = 1'b0;  b8.signed_mode = 1'b0;  b8.mcand = 8'd0;  b8.mplr = 8'd0;
      b16.start = 1'b0; b16.signed_mode = 1'b0; b16.mcand = 16'd0; b16.mplr = 16'd0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (b8.busy !== 1'b0 || b8.done !== 1'b0 || b8.prod !== 16'h0000) begin
         bad++;
         $display("FAIL reset8: busy=%b done=%b prod=%h, want 0 0 0000",
                  b8.busy, b8.done, b8.prod);
      end
      total++;
      if (b16.busy !== 1'b0 || b16.done !== 1'b0 || b16.prod !== 32'h0) begin
         bad++;
         $display("FAIL reset16: busy=%b done=%b prod=%h, want 0 0 0",
                  b16.busy, b16.done, b16.prod);
      end
      // start in the very first cycle out of reset must be taken
      rst = 1'b0;
      op8(1'b0, 8'd3, 8'd4, 16'd12, "first_start");
   endtask

   task automatic test_unsigned;
      op8(1'b0, 8'd255, 8'd255, 16'hFE01, "u255x255");
      op8(1'b0, 8'd3,   8'd7,   16'd21,   "u3x7");
      op8(1'b0, 8'h80,  8'h80,  16'h4000, "u128x128");
      op8(1'b0, 8'hFF,  8'h01,  16'h00FF, "u255x1");
      op8(1'b0, 8'd0,   8'd0,   16'h0000, "u0x0");
   endtask

   task automatic test_signed;
      op8(1'b1, 8'h80, 8'h80, 16'h4000, "s-128x-128");
      op8(1'b1, 8'hFF, 8'h01, 16'hFFFF, "s-1x1");
      op8(1'b1, 8'h00, 8'h80, 16'h0000, "s0x-128");
      op8(1'b1, 8'hFD, 8'h07, 16'hFFEB, "s-3x7");
      op8(1'b1, 8'h80, 8'h7F, 16'hC080, "s-128x127");
      op8(1'b1, 8'h80, 8'hFF, 16'h0080, "s-128x-1");
      op8(1'b1, 8'hFB, 8'h00, 16'h0000, "s-5x0");
   endtask

   task automatic test_ignore_start;
      int ndone;
      int lat;
      logic [15:0] got;
      ndone = 0; lat = 0; got = 16'h0;
      b8.signed_mode = 1'b0; b8.mcand = 8'd3; b8.mplr = 8'd7; b8.start = 1'b1;
      @(negedge clk);
      b8.start = 1'b0;
      @(negedge clk);
      b8.mcand = 8'd9; b8.mplr = 8'd9; b8.start = 1'b1;
      @(negedge clk);
      b8.start = 1'b0;
      for (int i = 3; i <= 12; i++) begin
         if (b8.done === 1'b1) begin
            ndone++;
            lat = i;
            got = b8.prod;
         end
         @(negedge clk);
      end
      total++;
      if (ndone != 1 || lat != 5) begin
         bad++;
         $display("FAIL ignore_start done count: got %0d dones (last at cycle %0d), want 1 at cycle 5",
                  ndone, lat);
      end
      total++;
      if (got !== 16'd21) begin
         bad++;
         $display("FAIL ignore_start prod: got %0d, want 21", got);
      end
   endtask

   task automatic test_reset_abort;
      int ndone;
      ndone = 0;
      b8.signed_mode = 1'b0; b8.mcand = 8'd100; b8.mplr = 8'd100; b8.start = 1'b1;
      @(negedge clk);
      b8.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (b8.busy !== 1'b0 || b8.done !== 1'b0 || b8.prod !== 16'h0000) begin
         bad++;
         $display("FAIL reset_abort state: busy=%b done=%b prod=%h, want 0 0 0000",
                  b8.busy, b8.done, b8.prod);
      end
      for (int i = 0; i < 8; i++) begin
         if (b8.done === 1'b1 || b8.busy === 1'b1) ndone++;
         @(negedge clk);
      end
      total++;
      if (ndone != 0) begin
         bad++;
         $display("FAIL reset_abort activity: %0d cycles with busy/done after reset, want 0", ndone);
      end
      op8(1'b0, 8'd12, 8'd12, 16'd144, "after_abort");
   endtask

   task automatic test_back_to_back;
      int lat;
      lat = 0;
      b8.signed_mode = 1'b0; b8.mcand = 8'd10; b8.mplr = 8'd10; b8.start = 1'b1;
      for (int i = 1; i <= 4; i++) @(negedge clk);
      b8.mcand = 8'd5; b8.mplr = 8'd6;
      @(negedge clk);
      total++;
      if (b8.done !== 1'b1 || b8.prod !== 16'd100) begin
         bad++;
         $display("FAIL b2b first: done=%b prod=%0d, want done=1 prod=100", b8.done, b8.prod);
      end
      @(negedge clk);
      b8.start = 1'b0;
      total++;
      if (b8.busy !== 1'b1 || b8.done !== 1'b0) begin
         bad++;
         $display("FAIL b2b reaccept: busy=%b done=%b, want busy=1 done=0", b8.busy, b8.done);
      end
      for (int i = 1; i <= 10; i++) begin
         if (b8.done === 1'b1 && lat == 0) lat = i;
         if (lat == 0) @(negedge clk);
      end
      total++;
      if (lat != 5 || b8.prod !== 16'd30) begin
         bad++;
         $display("FAIL b2b second: done %0d cycles after first, prod=%0d, want 5 and 30",
                  lat, b8.prod);
      end
      @(negedge clk);
   endtask

   // One 16-bit multiply with latency measured from the accepting edge.
   task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b);
      longint pa;
      logic [31:0] exp;
      int lat;
      if (sm) pa = longint'($signed(a)) * longint'($signed(b));
      else    pa = longint'(a) * longint'(b);
      exp = pa[31:0];
      lat = 0;
      b16.signed_mode = sm; b16.mcand = a; b16.mplr = b; b16.start = 1'b1;
      @(negedge clk);
      b16.start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (lat == 0 && b16.done === 1'b1) lat = i;
         if (lat == 0) @(negedge clk);
      end
      total++;
      if (lat != 9) begin
         bad++;
         $display("FAIL w16 latency sm=%b %h*%h: done at cycle %0d, want 9", sm, a, b, lat);
      end
      total++;
      if (b16.prod !== exp) begin
         bad++;
         $display("FAIL w16 prod sm=%b %h*%h: got %h, want %h", sm, a, b, b16.prod, exp);
      end
   endtask

   task automatic test_wide;
      op16(1'b1, 16'h8000, 16'h8000);
      op16(1'b0, 16'hFFFF, 16'hFFFF);
      op16(1'b1, 16'hFFFF, 16'h7FFF);
      op16(1'b1, 16'h0000, 16'hFFFF);
      for (int n = 0; n < 200; n++) begin
         op16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_unsigned;
      test_signed;
      test_ignore_start;
      test_reset_abort;
      test_back_to_back;
      test_wide;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/radix4_seq_mul.md
RADIX4_SEQ_MUL -- requirements
Module: radix4_seq_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; legal values are even and at least 4.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit; request to begin a multiply.
REQ-005 SHALL have port signed_mode, input, 1 bit; 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port mcand, input, WIDTH bits; multiplicand.
REQ-007 SHALL have port mplr, input, WIDTH bits; multiplier.
REQ-008 SHALL have port busy, output, 1 bit; high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit; single-cycle pulse marking prod valid.
REQ-010 SHALL have port prod, output, 2*WIDTH bits; registered product.

Function
REQ-011 SHALL implement three states: IDLE, RUN, DONE.
REQ-012 SHALL accept start only when busy=0 (IDLE or DONE); on acceptance it SHALL capture mcand, mplr and signed_mode at that edge.
REQ-013 SHALL ignore start while busy=1; captured operands SHALL NOT change.
REQ-014 In signed_mode=1, capture SHALL store operand magnitudes plus result sign = XOR of operand MSBs; in signed_mode=0, magnitudes SHALL equal the raw operands and the sign SHALL be 0.
REQ-015 RUN SHALL last exactly WIDTH/2 cycles, tracked by an iteration counter of ceil(log2(WIDTH/2))+1 bits.
REQ-016 Each RUN cycle SHALL consume the 2 LSBs of the multiplier register and add 0, 1x, 2x or 3x the multiplicand magnitude, shifted left by 2*iteration, into a 2*WIDTH-bit accumulator.
REQ-017 After each addition the multiplier register SHALL shift right by 2.
REQ-018 3x SHALL be formed as mcand + (mcand<<1) at WIDTH+2 bits, with no truncation.
REQ-019 After the final RUN cycle the block SHALL enter DONE, load prod with the accumulator (two's-complement negated if sign=1), and assert done for exactly one cycle.
REQ-020 Latency SHALL be fixed: done is high in cycle WIDTH/2+1 after the accepting edge (5 cycles for WIDTH=8), independent of operand values.
REQ-021 busy SHALL be high from the cycle after acceptance through the last RUN cycle, and low in DONE and IDLE.
REQ-022 start asserted during DONE SHALL be accepted, giving back-to-back throughput of one result per WIDTH/2+1 cycles; without start, DONE SHALL go to IDLE.
REQ-023 prod SHALL hold its value until the next DONE.
REQ-024 The most negative signed operand (magnitude 2^(WIDTH-1)) SHALL be handled without overflow.
REQ-025 A zero operand SHALL still take the full latency and return 0 with sign forced to 0, so no negative zero results.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, prod=0, and clear the accumulator, counter and operand registers.
REQ-027 rst SHALL take priority over start and over any in-flight operation; an operation aborted by reset SHALL NOT produce done.
REQ-028 The first start SHALL be accepted in the first cycle with rst=0.

Verification
REQ-029 WIDTH=8, unsigned, mcand=255, mplr=255, start for 1 cycle -> busy high for 4 cycles, then done for 1 cycle with prod=0xFE01.
REQ-030 WIDTH=8, signed, mcand=0x80, mplr=0x80 -> prod=0x4000; mcand=0xFF, mplr=0x01 -> prod=0xFFFF; mcand=0x00, mplr=0x80 -> prod=0x0000.
REQ-031 start=1 with 3x7 unsigned, then start=1 with 9x9 two cycles later -> only one done, prod=21; the second request is ignored.
REQ-032 Assert rst on the 2nd RUN cycle of 100x100 -> next cycle busy=0, done=0, prod=0; no done follows; a fresh 12x12 then returns 144.
REQ-033 Back-to-back: hold start high across DONE with new operands 5x6 after 10x10 -> done pulses 5 cycles apart, prod=100 then 30.
REQ-034 WIDTH=16, 200 random signed and unsigned pairs -> every prod matches the reference product, with done exactly 9 cycles after acceptance.
